// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register: picks write-back data from NSRC sources, tracks
// validity, ages Tnew (also while stalled) and counts retired instructions.
module wb_stage_reg #(
  parameter int DW   = 32,
  parameter int AW   = 5,
  parameter int TW   = 2,
  parameter int NSRC = 4,
  parameter int SELW = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [DW-1:0]      pc_i,
  input  logic [TW-1:0]      Tnew_i,
  input  logic [NSRC*DW-1:0] src_i,
  input  logic [SELW-1:0]    wd_sel_i,
  input  logic               RegWE_i,
  input  logic [AW-1:0]      a3_i,
  output logic               valid_o,
  output logic [DW-1:0]      pc_o,
  output logic [TW-1:0]      Tnew_o,
  output logic               RegWE_o,
  output logic [DW-1:0]      wd_o,
  output logic [AW-1:0]      a3_o,
  output logic               fwd_en_o,
  output logic [31:0]        retire_cnt_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [TW-1:0] tnew_q, tnew_d;
  logic          we_q, we_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [AW-1:0] a3_q, a3_d;
  logic [31:0]   cnt_q, cnt_d;

  logic [DW-1:0] src_arr [NSRC];
  logic [DW-1:0] wd_mux;

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign src_arr[gi] = src_i[gi*DW +: DW];
  end

  // Select values at or above NSRC fall through to zero.
  always_comb begin
    wd_mux = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(wd_sel_i) == k) wd_mux = src_arr[k];
    end
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    tnew_d  = (tnew_q == '0) ? '0 : tnew_q - 1'b1;
    we_d    = we_q;
    wd_d    = wd_q;
    a3_d    = a3_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      valid_d = 1'b0;
      pc_d    = '0;
      tnew_d  = '0;
      we_d    = 1'b0;
      wd_d    = '0;
      a3_d    = '0;
    end else if (!stall_i) begin
      valid_d = valid_i;
      pc_d    = pc_i;
      tnew_d  = (Tnew_i == '0) ? '0 : Tnew_i - 1'b1;
      we_d    = RegWE_i & valid_i & (a3_i != '0);
      wd_d    = wd_mux;
      a3_d    = a3_i;
      cnt_d   = cnt_q + {31'd0, valid_i};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      tnew_q  <= '0;
      we_q    <= 1'b0;
      wd_q    <= '0;
      a3_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      tnew_q  <= tnew_d;
      we_q    <= we_d;
      wd_q    <= wd_d;
      a3_q    <= a3_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o      = valid_q;
  assign pc_o         = pc_q;
  assign Tnew_o       = tnew_q;
  assign RegWE_o      = we_q;
  assign wd_o         = wd_q;
  assign a3_o         = a3_q;
  assign fwd_en_o     = we_q & (a3_q != '0) & (tnew_q == '0);
  assign retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed bench for wb_stage_reg: table of load/stall/flush vectors plus
// hand-written sequences for async reset and counter wrap.
module tb_wb_stage_reg;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall_i, flush_i, valid_i, RegWE_i;
  logic [31:0]  pc_i;
  logic [1:0]   Tnew_i, wd_sel_i;
  logic [127:0] src_i;
  logic [4:0]   a3_i;

  logic         valid_o, RegWE_o, fwd_en_o;
  logic [31:0]  pc_o, wd_o, retire_cnt_o;
  logic [1:0]   Tnew_o;
  logic [4:0]   a3_o;

  logic         valid3_o, RegWE3_o, fwd3_o;
  logic [31:0]  pc3_o, wd3_o, cnt3_o;
  logic [1:0]   Tnew3_o;
  logic [4:0]   a33_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage_reg dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .pc_i(pc_i), .Tnew_i(Tnew_i), .src_i(src_i),
    .wd_sel_i(wd_sel_i), .RegWE_i(RegWE_i), .a3_i(a3_i),
    .valid_o(valid_o), .pc_o(pc_o), .Tnew_o(Tnew_o), .RegWE_o(RegWE_o),
    .wd_o(wd_o), .a3_o(a3_o), .fwd_en_o(fwd_en_o), .retire_cnt_o(retire_cnt_o)
  );

  wb_stage_reg #(.NSRC(3)) dut3 (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .pc_i(pc_i), .Tnew_i(Tnew_i), .src_i(src_i[95:0]),
    .wd_sel_i(wd_sel_i), .RegWE_i(RegWE_i), .a3_i(a3_i),
    .valid_o(valid3_o), .pc_o(pc3_o), .Tnew_o(Tnew3_o), .RegWE_o(RegWE3_o),
    .wd_o(wd3_o), .a3_o(a33_o), .fwd_en_o(fwd3_o), .retire_cnt_o(cnt3_o)
  );

  typedef struct {
    logic        stall, flush, valid, we;
    logic [31:0] pc;
    logic [1:0]  tnew, sel;
    logic [4:0]  a3;
    logic        e_valid, e_we, e_fwd;
    logic [31:0] e_pc, e_wd, e_wd3, e_cnt;
    logic [1:0]  e_tnew;
    logic [4:0]  e_a3;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input logic v, input logic [31:0] pc, input logic [1:0] tn,
                         input logic we, input logic [31:0] wd, input logic [4:0] a3,
                         input logic fwd, input logic [31:0] cnt);
    chk("valid_o", 64'(valid_o), 64'(v));
    chk("pc_o", 64'(pc_o), 64'(pc));
    chk("Tnew_o", 64'(Tnew_o), 64'(tn));
    chk("RegWE_o", 64'(RegWE_o), 64'(we));
    chk("wd_o", 64'(wd_o), 64'(wd));
    chk("a3_o", 64'(a3_o), 64'(a3));
    chk("fwd_en_o", 64'(fwd_en_o), 64'(fwd));
    chk("retire_cnt_o", 64'(retire_cnt_o), 64'(cnt));
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic we,
                       input logic [31:0] pc, input logic [1:0] tn, input logic [1:0] sel,
                       input logic [4:0] a3);
    stall_i = st; flush_i = fl; valid_i = v; RegWE_i = we;
    pc_i = pc; Tnew_i = tn; wd_sel_i = sel; a3_i = a3;
  endtask

  initial begin
    //          st fl v  we pc            tn sel a3 | eV eWE fwd ePC         eWD    eWD3   cnt eTn eA3
    vecs[0]  = '{0, 0, 1, 1, 32'h100, 2, 0, 8,    1, 1, 0, 32'h100, 32'h11, 32'h11, 1, 1, 8};
    vecs[1]  = '{0, 0, 1, 1, 32'h104, 2, 1, 8,    1, 1, 0, 32'h104, 32'h22, 32'h22, 2, 1, 8};
    vecs[2]  = '{0, 0, 1, 1, 32'h108, 2, 2, 8,    1, 1, 0, 32'h108, 32'h33, 32'h33, 3, 1, 8};
    vecs[3]  = '{0, 0, 1, 1, 32'h10c, 2, 3, 8,    1, 1, 0, 32'h10c, 32'h44, 32'h0,  4, 1, 8};
    vecs[4]  = '{0, 0, 1, 1, 32'h110, 0, 1, 0,    1, 0, 0, 32'h110, 32'h22, 32'h22, 5, 0, 0};
    vecs[5]  = '{0, 0, 0, 1, 32'h114, 0, 1, 9,    0, 0, 0, 32'h114, 32'h22, 32'h22, 5, 0, 9};
    vecs[6]  = '{0, 0, 1, 1, 32'h118, 0, 0, 9,    1, 1, 1, 32'h118, 32'h11, 32'h11, 6, 0, 9};
    vecs[7]  = '{0, 0, 1, 1, 32'h11c, 3, 2, 10,   1, 1, 0, 32'h11c, 32'h33, 32'h33, 7, 2, 10};
    vecs[8]  = '{1, 0, 1, 1, 32'hdead, 1, 0, 1,   1, 1, 0, 32'h11c, 32'h33, 32'h33, 7, 1, 10};
    vecs[9]  = '{1, 0, 1, 1, 32'hdead, 1, 0, 1,   1, 1, 1, 32'h11c, 32'h33, 32'h33, 7, 0, 10};
    vecs[10] = '{1, 0, 1, 1, 32'hdead, 1, 0, 1,   1, 1, 1, 32'h11c, 32'h33, 32'h33, 7, 0, 10};
    vecs[11] = '{1, 1, 1, 1, 32'hbeef, 2, 1, 4,   0, 0, 0, 32'h0,   32'h0,  32'h0,  7, 0, 0};
    vecs[12] = '{0, 0, 1, 1, 32'h120, 1, 3, 3,    1, 1, 1, 32'h120, 32'h44, 32'h0,  8, 0, 3};
    vecs[13] = '{0, 1, 1, 1, 32'h124, 2, 0, 5,    0, 0, 0, 32'h0,   32'h0,  32'h0,  8, 0, 0};

    src_i = {32'h44, 32'h33, 32'h22, 32'h11};
    drive(0, 0, 1, 1, 32'h0, 2'd2, 2'd0, 5'd8);
    reset = 1'b0;
    #12;
    chk_all(0, 0, 0, 0, 0, 0, 0, 0);
    $display("reset held: all outputs zero checked");

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].we,
            vecs[i].pc, vecs[i].tnew, vecs[i].sel, vecs[i].a3);
      @(posedge clk);
      #1;
      chk_all(vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_tnew, vecs[i].e_we,
              vecs[i].e_wd, vecs[i].e_a3, vecs[i].e_fwd, vecs[i].e_cnt);
      chk("wd_o(NSRC=3)", 64'(wd3_o), 64'(vecs[i].e_wd3));
      $display("vec %0d: st=%0d fl=%0d v=%0d sel=%0d a3=%0d -> wd=%0h Tnew=%0d fwd=%0d cnt=%0d",
               i, stall_i, flush_i, valid_i, wd_sel_i, a3_i, wd_o, Tnew_o, fwd_en_o, retire_cnt_o);
      @(negedge clk);
    end

    // Mid-cycle async reset with valid contents loaded.
    drive(0, 0, 1, 1, 32'h200, 2'd1, 2'd1, 5'd7);
    @(posedge clk); #1;
    chk_all(1, 32'h200, 0, 1, 32'h22, 7, 1, 9);
    #2 reset = 1'b0;
    #1;
    chk_all(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    chk_all(0, 0, 0, 0, 0, 0, 0, 0);
    $display("async reset mid-cycle: outputs cleared, counter=%0d", retire_cnt_o);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 1, 1, 32'h204, 2'd2, 2'd2, 5'd6);
    @(posedge clk); #1;
    chk_all(1, 32'h204, 1, 1, 32'h33, 6, 0, 1);
    $display("first load after reset: pc=%0h cnt=%0d", pc_o, retire_cnt_o);

    // Counter wrap: preset the counter to all-ones, then one valid load.
    @(negedge clk);
    force dut.cnt_q = 32'hffff_ffff;
    #1;
    release dut.cnt_q;
    #1;
    chk("retire_cnt_o preset", 64'(retire_cnt_o), 64'hffff_ffff);
    drive(0, 0, 1, 1, 32'h208, 2'd0, 2'd0, 5'd2);
    @(posedge clk); #1;
    chk("retire_cnt_o wrap", 64'(retire_cnt_o), 64'h0);
    $display("counter wrap: cnt=%0h", retire_cnt_o);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
